// File: rtl/edp_muldiv_pkg.sv
// rtl/edp_muldiv_pkg.sv - shared types and constants for the EBOX multiply/divide sequencer
// Purpose: operation and FSM state encodings plus the radix-2 step count.
// Ports: none (package).
package edp_muldiv_pkg;

    typedef enum logic {
        MD_MUL = 1'b0,
        MD_DIV = 1'b1
    } muldiv_op_t;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        STEP,
        FIX,
        DONE
    } muldiv_state_t;

    // One quotient/multiplier bit retired per STEP cycle.
    localparam int MD_STEPS = 36;

endpackage

// File: rtl/muldiv_addsub.sv
// rtl/muldiv_addsub.sv - combinational add/subtract with carry-out for the muldiv step
// Purpose: a_i + b_i (sub_i=0) or a_i - b_i (sub_i=1); on subtract cout_o=1 means a_i >= b_i.
// Ports: a_i, b_i operands; sub_i selects subtract; sum_o N-bit result; cout_o carry/no-borrow.
module muldiv_addsub #(
    parameter int N = 38
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         sub_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    logic [N:0] full;

    assign full   = {1'b0, a_i} + {1'b0, (sub_i ? ~b_i : b_i)} + {{N{1'b0}}, sub_i};
    assign sum_o  = full[N-1:0];
    assign cout_o = full[N];

endmodule

// File: rtl/edp_muldiv_seq.sv
// rtl/edp_muldiv_seq.sv - radix-2 iterative signed multiply/divide sequencer
// Purpose: MUL gives the 2W-bit signed product of opa_hi*opb; DIV divides {opa_hi,opa_lo}
//          by opb with truncation toward zero, rejecting divides whose quotient would not fit.
// Ports: clk, reset (sync, active-high); start/op/abort control; opa_hi, opa_lo, opb operands;
//        busy, done, no_divide status; result_hi/result_lo double-word result.
module edp_muldiv_seq
    import edp_muldiv_pkg::*;
#(
    parameter int W    = 36,
    parameter int CNTW = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         op,
    input  logic         abort,
    input  logic [W-1:0] opa_hi,
    input  logic [W-1:0] opa_lo,
    input  logic [W-1:0] opb,
    output logic         busy,
    output logic         done,
    output logic         no_divide,
    output logic [W-1:0] result_hi,
    output logic [W-1:0] result_lo
);

    // Two guard bits: the magnitude of the most negative word and the
    // shifted remainder both need room above W bits.
    localparam int WX = W + 2;

    muldiv_state_t   state_q, state_d;
    muldiv_op_t      op_q;
    logic [W-1:0]    hi_q, lo_q, b_q;
    logic [WX-1:0]   mag_q;
    logic [WX-1:0]   acc_q;
    logic [W-1:0]    mq_q;
    logic [CNTW-1:0] cnt_q;
    logic            neg_q, rneg_q, rej_q;
    logic [W-1:0]    res_hi_q, res_lo_q;
    logic            nodiv_q;

    // Operand magnitudes, used only in PREP.
    logic [WX-1:0]   a_ext, b_ext, a_mag, b_mag, dvd_top;
    logic [2*W-1:0]  dvd, dvd_mag;
    logic            reject;

    assign a_ext   = {{2{hi_q[W-1]}}, hi_q};
    assign b_ext   = {{2{b_q[W-1]}}, b_q};
    assign a_mag   = hi_q[W-1] ? -a_ext : a_ext;
    assign b_mag   = b_q[W-1] ? -b_ext : b_ext;
    assign dvd     = {hi_q, lo_q};
    assign dvd_mag = hi_q[W-1] ? -dvd : dvd;
    assign dvd_top = {1'b0, dvd_mag[2*W-1:W-1]};
    assign reject  = (b_q == '0) || (dvd_top >= b_mag);

    // Shared step adder: MUL adds the multiplicand into the upper partial
    // product; DIV trial-subtracts the divisor from the shifted remainder.
    logic [WX-1:0] rem_sh, add_a, add_b, sum;
    logic          is_div, cout;

    assign is_div = (op_q == MD_DIV);
    assign rem_sh = {acc_q[WX-2:0], mq_q[W-1]};
    assign add_a  = is_div ? rem_sh : acc_q;
    assign add_b  = (is_div || mq_q[0]) ? mag_q : '0;

    muldiv_addsub #(.N(WX)) u_addsub (
        .a_i    (add_a),
        .b_i    (add_b),
        .sub_i  (is_div),
        .sum_o  (sum),
        .cout_o (cout)
    );

    // Sign fix-up for the FIX state.
    logic [2*W-1:0] prod_mag, prod;
    logic [W-1:0]   quot, rem;

    assign prod_mag = {acc_q[W-1:0], mq_q};
    assign prod     = neg_q ? -prod_mag : prod_mag;
    assign quot     = neg_q ? -mq_q : mq_q;
    assign rem      = rneg_q ? -acc_q[W-1:0] : acc_q[W-1:0];

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !abort) state_d = PREP;
            PREP:    state_d = (is_div && reject) ? FIX : STEP;
            STEP:    if (cnt_q == CNTW'(MD_STEPS - 1)) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= MD_MUL;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            mag_q    <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            rej_q    <= 1'b0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            nodiv_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        op_q <= muldiv_op_t'(op);
                        hi_q <= opa_hi;
                        lo_q <= opa_lo;
                        b_q  <= opb;
                    end
                end
                PREP: begin
                    cnt_q  <= '0;
                    neg_q  <= hi_q[W-1] ^ b_q[W-1];
                    rneg_q <= hi_q[W-1];
                    rej_q  <= is_div && reject;
                    if (is_div) begin
                        mag_q <= b_mag;
                        acc_q <= {2'b00, dvd_mag[2*W-1:W]};
                        mq_q  <= dvd_mag[W-1:0];
                    end else begin
                        mag_q <= a_mag;
                        acc_q <= '0;
                        mq_q  <= b_mag[W-1:0];
                    end
                end
                STEP: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (is_div) begin
                        acc_q <= cout ? sum : rem_sh;
                        mq_q  <= {mq_q[W-2:0], cout};
                    end else begin
                        acc_q <= {1'b0, sum[WX-1:1]};
                        mq_q  <= {sum[0], mq_q[W-1:1]};
                    end
                end
                FIX: begin
                    if (!abort) begin
                        nodiv_q <= rej_q;
                        if (rej_q) begin
                            res_hi_q <= hi_q;
                            res_lo_q <= lo_q;
                        end else if (is_div) begin
                            res_hi_q <= quot;
                            res_lo_q <= rem;
                        end else begin
                            res_hi_q <= prod[2*W-1:W];
                            res_lo_q <= prod[W-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE) && !abort;
    assign no_divide = nodiv_q;
    assign result_hi = res_hi_q;
    assign result_lo = res_lo_q;

endmodule

// File: doc/edp_muldiv_seq.md
Name: edp_muldiv_seq

Overview:
- Iterative signed multiply/divide sequencer that sits directly downstream of the EBOX data path.
- Consumes operand words latched from AR, ARX, MQ and BR.
- Produces a double-word result to be loaded back into AR/ARX (high/low) through the AR/ARX mux inputs.
- Steps one bit per clock, radix-2, so that MUL/DIV no longer burn microcode loop cycles through AD/MQ shifting.

Parameters:
- W, 36, data word width; all arithmetic is two's complement on W bits.
- CNTW, 6, step counter width; must hold W.

Ports:
- clk  input  1  EBOX data path clock; the single clock for the block.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- op  input  1  0 = MUL, 1 = DIV.
- abort  input  1  synchronous cancel of an in-flight operation.
- opa_hi  input  W  MUL: multiplicand. DIV: dividend high word.
- opa_lo  input  W  MUL: ignored. DIV: dividend low word.
- opb  input  W  MUL: multiplier. DIV: divisor.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; result valid.
- no_divide  output  1  DIV rejected; held with the result.
- result_hi  output  W  MUL: product bits 0:35. DIV: quotient.
- result_lo  output  W  MUL: product bits 36:71. DIV: remainder.

Behaviour:
- Reset values: busy=0, done=0, no_divide=0, result_hi=0, result_lo=0, state=IDLE, step counter=0.
- States and transitions:
  - IDLE: start=1 captures op and operands into internal registers and moves to PREP. start=0 stays in IDLE.
  - PREP: takes operand magnitudes and records the result signs.
    - MUL moves to STEP.
    - DIV moves to FIX with no_divide=1 if divisor==0 or (|dividend| >> 35) >= |divisor|.
    - Otherwise DIV moves to STEP.
  - STEP: exactly 36 cycles, counter 0..35. Moves to FIX after the step with counter==35.
    - MUL: shift-add. If multiplier LSB==1, add magnitude of multiplicand into the upper partial product; then shift the {upper, multiplier} pair right by 1.
    - DIV: restoring division. Shift the {rem, quot} pair left by 1; if rem >= |divisor|, subtract and set quotient LSB=1.
  - FIX: applies signs and loads the result registers; moves to DONE.
    - MUL: product negated if signs differ. The full 72-bit two's complement product goes to result_hi:result_lo. No overflow is possible; -2^35 * -2^35 = 2^70 fits.
    - DIV: quotient negated if signs differ; remainder takes the sign of the dividend (truncation toward zero).
    - DIV with no_divide=1: result_hi=opa_hi and result_lo=opa_lo, unchanged.
  - DONE: done=1 for exactly this cycle; moves to IDLE.
- Latency, counting clock edges from the edge that sampled start to entering DONE:
  - MUL and normal DIV: 38.
  - No-divide DIV: 2.
- busy rises on the edge after start is sampled and falls on entering IDLE.
- Result registers change only in FIX. They hold until the next FIX, reset, or abort; abort leaves them unchanged.
- no_divide is updated only in FIX: cleared for MUL and successful DIV, set for a rejected DIV.
- Boundary cases:
  - start while busy: ignored; no queuing.
  - start in DONE: ignored; the caller must wait for IDLE.
  - abort in any non-IDLE state: next state IDLE, no done pulse, results and no_divide unchanged. abort in IDLE: no effect. abort together with start in IDLE: start is ignored.
  - reset during an operation: all outputs return to their reset values on the next edge.
  - Operands are captured at start; later input changes have no effect.
  - Internal datapath is W+2 bits wide so that the -2^35 magnitude and the remainder compare never overflow.

Decomposition:
- Package edp_muldiv_pkg holds:
  - typedef muldiv_op_t {MD_MUL, MD_DIV};
  - typedef muldiv_state_t {IDLE, PREP, STEP, FIX, DONE};
  - constant MD_STEPS = 36.
- One sub-module, muldiv_addsub: a combinational (W+2)-bit add/subtract with carry-out, shared by both the STEP add and the STEP compare/subtract.

Test Plan:
- MUL opa_hi=3, opb=-5 (777777777773 octal) -> done 38 cycles after start; result_hi=777777777777, result_lo=777777777761 (octal); no_divide=0.
- MUL opa_hi=opb=400000000000 (octal) -> result_hi=200000000000, result_lo=0.
- DIV dividend hi=0 / lo=144 (octal), divisor 7 -> quotient 16, remainder 2 (octal). DIV dividend hi=777777777777 / lo=777777777634 (octal), divisor 7 -> quotient 777777777762, remainder 777777777776 (octal).
- DIV divisor 0, and DIV hi=1 / lo=0 with divisor 1 -> each enters DONE 2 edges after start with no_divide=1, result_hi=opa_hi, result_lo=opa_lo.
- abort at step 10 of a MUL, then start raised during the abort cycle -> no done pulse, prior results held, busy=0; a new start one cycle later completes normally.
- start re-asserted every cycle during an operation, and reset at step 20 -> only the first request runs; after reset all outputs are 0 and the state is IDLE.
